// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store sequencer between the multicycle CPU datapath and a byte-
// addressed, little-endian data memory with a 32-bit word port (write on
// posedge clk, combinational read). CPU byte/half/word accesses become aligned
// word accesses. Narrow stores use read-modify-write. Loads are extracted and
// sign- or zero-extended. Misaligned, illegal-size and out-of-range requests
// complete with fault=1 and never touch memory.
//
// Optional feature macro: MEMCTRL_PERF_EN adds the completed-access counters
// ld_cnt / st_cnt (saturating, 16 bit).
//
// Handshake: req is sampled only in IDLE. There is no backpressure: a req
// seen while busy=1 (including the DONE cycle) is dropped, not queued. done is
// a single-cycle pulse, and fault is qualified by done. rdata keeps its value
// until the next load (or fault) completes.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req, wr, size, uns    request, 1=store, 00/01/10 = byte/half/word, 1=zero-ext
//   addr, wdata           CPU byte address, store data (low bits for narrow)
//   rdata, done, fault    extended load result, completion pulse, fault flag
//   busy                  high in every state except IDLE
//   dm_addr, dm_din,      word-aligned memory address, write word,
//   dm_we, dm_dout        write enable, read word
//   ld_cnt, st_cnt        (MEMCTRL_PERF_EN only) completed load/store counts
//   dbg_state             current FSM state, for debug/checkers
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int MEM_BYTES = 12288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              fault,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout,
`ifdef MEMCTRL_PERF_EN
  output logic [15:0]       ld_cnt,
  output logic [15:0]       st_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [31:0] MAX_BASE = 32'(MEM_BYTES - 4);

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rd_q, rd_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                fault_q, fault_d;

  logic [31:0]         req_base;
  logic                req_fault;
  logic [31:0]         ld_shift;
  logic [31:0]         ld_val;
  logic [31:0]         st_merge;

  // Fault check on the request as it is latched in IDLE.
  always_comb begin
    req_base  = 32'({addr[ADDR_W-1:2], 2'b00});
    req_fault = 1'b0;
    if (size == 2'b11)                       req_fault = 1'b1;
    if ((size == 2'b01) && addr[0])          req_fault = 1'b1;
    if ((size == 2'b10) && (addr[1:0] != 2'b00)) req_fault = 1'b1;
    if (req_base > MAX_BASE)                 req_fault = 1'b1;
  end

  // Load extraction. Legal halves have addr_q[0]=0, so one byte-granular
  // shift serves both byte and half lanes.
  always_comb begin
    ld_shift = dm_dout >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, ld_shift[7:0]}
                              : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_val = uns_q ? {16'h0, ld_shift[15:0]}
                              : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_val = dm_dout;
    endcase
  end

  // Store merge: replace the addressed lane of the word read in ACCESS.
  always_comb begin
    st_merge = rd_q;
    case (size_q)
      2'b00:   st_merge[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   st_merge[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: st_merge = wdata_q;
    endcase
  end

  // Next-state / datapath.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr;
          wdata_d = wdata;
          if (req_fault) begin
            fault_d = 1'b1;
            rdata_d = 32'h0;
            state_d = S_DONE;
          end else begin
            fault_d = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        rd_d = dm_dout;
        if (wr_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = ld_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd_q    <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // dm_we decodes straight from the state flop so an async reset in WRITE
  // drops it immediately and no partial write can land.
  assign dm_we     = (state_q == S_WRITE);
  assign dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_din    = st_merge;
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_DONE) && fault_q;
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

`ifdef MEMCTRL_PERF_EN
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic [15:0] st_cnt_q, st_cnt_d;

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if ((state_q == S_DONE) && !fault_q) begin
      if (wr_q) begin
        if (st_cnt_q != 16'hFFFF) st_cnt_d = st_cnt_q + 16'd1;
      end else begin
        if (ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= 16'h0;
      st_cnt_q <= 16'h0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign ld_cnt = ld_cnt_q;
  assign st_cnt = st_cnt_q;
`endif

endmodule
